// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared state, light and phase-duration definitions for the T-junction controller
//
// Contents:
//   state_t      : phase encoding S0..S5 (3-bit; codes 6 and 7 are illegal)
//   RED/YEL/GRN  : signal head encodings {red,yellow,green}, one-hot
//   T_*_DEF      : default phase lengths in clock cycles
//   dur()        : phase length for a state, given the configured durations
//   next_state() : phase successor; illegal codes recover to S0

package tlc_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam int unsigned T_MAIN_DEF = 7;
    localparam int unsigned T_YEL_DEF  = 2;
    localparam int unsigned T_TURN_DEF = 5;
    localparam int unsigned T_SIDE_DEF = 3;

    // Durations run 1..16, so the result needs 5 bits. Illegal states get a
    // length of 1 so the timer terminates on the very next edge.
    function automatic logic [4:0] dur(
        input state_t      s,
        input int unsigned t_main,
        input int unsigned t_yel,
        input int unsigned t_turn,
        input int unsigned t_side
    );
        logic [4:0] d;
        case (s)
            S0:             d = 5'(t_main);
            S1, S3, S5:     d = 5'(t_yel);
            S2:             d = 5'(t_turn);
            S4:             d = 5'(t_side);
            default:        d = 5'd1;
        endcase
        return d;
    endfunction

    function automatic state_t next_state(input state_t s);
        state_t n;
        case (s)
            S0:      n = S1;
            S1:      n = S2;
            S2:      n = S3;
            S3:      n = S4;
            S4:      n = S5;
            default: n = S0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// rtl/tlc_phase_timer.sv - per-phase cycle counter with terminal-count flag
//
// Ports:
//   clk      in  1  rising-edge clock
//   rst      in  1  asynchronous active-low reset
//   load_dur in  4  terminal count for the current phase (phase length - 1)
//   count    out 4  cycles elapsed in the current phase (registered)
//   done     out 1  high in the last cycle of the phase

module tlc_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] load_dur,
    output logic [3:0] count,
    output logic       done
);

    assign done = (count == load_dur);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 4'd0;
        end else if (done) begin
            count <= 4'd0;
        end else begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/traffic_light_controller.sv
// rtl/traffic_light_controller.sv - fixed-time six-phase controller for a T-junction
//
// Ports:
//   clk         in  1  rising-edge clock
//   rst         in  1  asynchronous active-low reset
//   light_L_R   out 3  L->R head {red,yellow,green}
//   light_D_R   out 3  D->R head
//   light_R_L_D out 3  R->L / R->D head
//   light_L_D   out 3  L->D turn head
//   count       out 4  cycles elapsed in the current phase
//   ps          out 3  present state

module traffic_light_controller
    import tlc_pkg::*;
#(
    parameter int unsigned T_MAIN = T_MAIN_DEF,
    parameter int unsigned T_YEL  = T_YEL_DEF,
    parameter int unsigned T_TURN = T_TURN_DEF,
    parameter int unsigned T_SIDE = T_SIDE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] light_L_R,
    output logic [2:0] light_D_R,
    output logic [2:0] light_R_L_D,
    output logic [2:0] light_L_D,
    output logic [3:0] count,
    output logic [2:0] ps
);

    if (T_MAIN < 1 || T_MAIN > 16 || T_YEL < 1 || T_YEL > 16 ||
        T_TURN < 1 || T_TURN > 16 || T_SIDE < 1 || T_SIDE > 16) begin : g_cfg_error
        $error("traffic_light_controller: phase durations must be in 1..16");
    end

    state_t     ps_q;
    logic [4:0] cur_dur;
    logic [3:0] load_dur;
    logic       done;

    always_comb begin
        cur_dur  = dur(ps_q, T_MAIN, T_YEL, T_TURN, T_SIDE);
        // A 16-cycle phase maps to terminal count 15, so 4 bits suffice.
        load_dur = 4'(cur_dur - 5'd1);
    end

    tlc_phase_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_dur (load_dur),
        .count    (count),
        .done     (done)
    );

    // Illegal codes have a terminal count of 0, so done is high and the
    // next edge lands in S0 with the counter cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q <= S0;
        end else if (done) begin
            ps_q <= next_state(ps_q);
        end
    end

    assign ps = ps_q;

    always_comb begin
        light_L_R   = RED;
        light_D_R   = RED;
        light_R_L_D = RED;
        light_L_D   = RED;
        case (ps_q)
            S0: begin
                light_L_R   = GRN;
                light_R_L_D = GRN;
            end
            S1: begin
                light_L_R   = GRN;
                light_R_L_D = YEL;
            end
            S2: begin
                light_L_R   = GRN;
                light_L_D   = GRN;
            end
            S3: begin
                light_L_R   = YEL;
                light_L_D   = YEL;
            end
            S4: light_D_R = GRN;
            S5: light_D_R = YEL;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_controller.sv
// tb/tb_traffic_light_controller.sv - directed self-checking bench for traffic_light_controller

module tb_traffic_light_controller;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk;
    logic       rst;
    logic [2:0] light_L_R;
    logic [2:0] light_D_R;
    logic [2:0] light_R_L_D;
    logic [2:0] light_L_D;
    logic [3:0] count;
    logic [2:0] ps;

    int n_checks;
    int n_fail;

    traffic_light_controller dut (
        .clk         (clk),
        .rst         (rst),
        .light_L_R   (light_L_R),
        .light_D_R   (light_D_R),
        .light_R_L_D (light_R_L_D),
        .light_L_D   (light_L_D),
        .count       (count),
        .ps          (ps)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lights packed as {L_R, R_L_D, D_R, L_D}.
    function automatic logic [15:0] lights();
        return {4'h0, light_L_R, light_R_L_D, light_D_R, light_L_D};
    endfunction

    function automatic logic [15:0] pat(input logic [2:0] lr, input logic [2:0] rld,
                                        input logic [2:0] dr, input logic [2:0] ld);
        return {4'h0, lr, rld, dr, ld};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic safe;
        logic onehot;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;

        // Reset with no clock edge yet (first rising edge is at t=5).
        #3 rst = 1'b0;
        #1;
        chk("reset_ps",     16'(ps),    16'd0);
        chk("reset_count",  16'(count), 16'd0);
        chk("reset_lights", lights(),   pat(G, G, R, R));

        // Release between edges; edge 1 follows at t=15.
        #8 rst = 1'b1;

        for (int k = 1; k <= 6; k++) begin
            tick(1);
            chk($sformatf("s0_count_%0d", k), 16'(count), 16'(k));
            chk($sformatf("s0_ps_%0d", k),    16'(ps),    16'd0);
        end
        tick(1);  // edge 7
        chk("e7_ps",     16'(ps),    16'd1);
        chk("e7_count",  16'(count), 16'd0);
        chk("s1_lights", lights(),   pat(G, Y, R, R));
        tick(1);  // edge 8
        chk("e8_count",  16'(count), 16'd1);
        chk("e8_ps",     16'(ps),    16'd1);
        tick(1);  // edge 9
        chk("e9_ps",     16'(ps),    16'd2);
        chk("e9_count",  16'(count), 16'd0);
        chk("s2_lights", lights(),   pat(G, R, R, G));
        tick(5);  // edge 14
        chk("e14_ps",    16'(ps),    16'd3);
        chk("s3_lights", lights(),   pat(Y, R, R, Y));
        tick(2);  // edge 16
        chk("e16_ps",    16'(ps),    16'd4);
        chk("s4_lights", lights(),   pat(R, R, G, R));
        tick(3);  // edge 19
        chk("e19_ps",    16'(ps),    16'd5);
        chk("s5_lights", lights(),   pat(R, R, Y, R));
        tick(2);  // edge 21
        chk("e21_ps",    16'(ps),    16'd0);
        chk("e21_count", 16'(count), 16'd0);
        chk("wrap_lights", lights(), pat(G, G, R, R));

        // S2 begins 9 edges into the cycle; count=3 three edges later.
        tick(12);
        chk("mid_s2_ps",    16'(ps),    16'd2);
        chk("mid_s2_count", 16'(count), 16'd3);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_ps",     16'(ps),    16'd0);
        chk("async_rst_count",  16'(count), 16'd0);
        chk("async_rst_lights", lights(),   pat(G, G, R, R));
        #2 rst = 1'b1;
        tick(6);
        chk("restart_s0_ps",    16'(ps),    16'd0);
        chk("restart_s0_count", 16'(count), 16'd6);
        tick(1);
        chk("restart_s1_ps",    16'(ps),    16'd1);
        chk("restart_s1_count", 16'(count), 16'd0);

        // Safety monitor over three full cycles.
        for (int e = 0; e < 63; e++) begin
            tick(1);
            onehot = $onehot(light_L_R) && $onehot(light_D_R) &&
                     $onehot(light_R_L_D) && $onehot(light_L_D);
            safe = !((light_R_L_D != R) && ((light_L_D != R) || (light_D_R != R))) &&
                   !((light_D_R != R) && (light_L_R != R));
            chk($sformatf("onehot_e%0d", e), 16'(onehot), 16'd1);
            chk($sformatf("safety_e%0d", e), 16'(safe),   16'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
